// File: rtl/pless_mem_arbiter_pkg.sv
// Shared types and constants for the scratch-memory arbiter.
package pless_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Width of an owner / round-robin pointer index (at least one bit).
    function automatic int owner_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Round-robin pointer value after reset: requester 0 goes first.
    localparam int RR_PTR_RST = 0;

endpackage

// File: rtl/pless_mem_arbiter_if.sv
// Requester bus plus memory port of the scratch-memory arbiter.
// slave = arbiter side, master = requesters/memory side.
interface pless_mem_arbiter_if #(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        we;
    logic [N_REQ-1:0]        last;
    logic [N_REQ*ADDR_W-1:0] addr;
    logic [N_REQ*DATA_W-1:0] wdata;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]       rdata;
    logic                    mem_en;
    logic                    mem_we;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W-1:0]       mem_wdata;
    logic [DATA_W-1:0]       mem_rdata;
    logic                    busy;
    logic                    err_timeout;

    modport slave (
        input  req, we, last, addr, wdata, mem_rdata,
        output gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy, err_timeout
    );

    modport master (
        output req, we, last, addr, wdata, mem_rdata,
        input  gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy, err_timeout
    );
endinterface

// File: rtl/pless_rr_picker.sv
// Rotating-priority encoder: first requester at or after rr_ptr, cyclically.
module pless_rr_picker
    import pless_arb_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int OW    = owner_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [OW-1:0]    rr_ptr,
    output logic             found,
    output logic [OW-1:0]    winner
);

    // Scan from rr_ptr upward with wrap; the first hit wins.
    always_comb begin
        int idx;
        idx    = 0;
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % N_REQ;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = OW'(idx);
            end
        end
    end

endmodule

// File: rtl/pless_mem_arbiter.sv
// Round-robin arbiter/sequencer for the shared single-port scratch memory.
// Optional burst-length watchdog enabled by defining PLESS_ARB_TIMEOUT_EN.
module pless_mem_arbiter
    import pless_arb_pkg::*;
#(
    parameter int N_REQ     = 3,
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 8,
    parameter int MAX_BEATS = 8
) (
    input logic               clk,
    input logic               rst_n,
    pless_mem_arbiter_if.slave bus
);

    localparam int OW = owner_w(N_REQ);

    arb_state_e        state_q, state_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic [OW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [N_REQ-1:0]  rvalid_q, rvalid_d;
    logic              found;
    logic [OW-1:0]     winner;
    logic              beat;
    logic              release_burst;
    logic              force_rel;
    logic [OW-1:0]     rr_next;

    pless_rr_picker #(.N_REQ(N_REQ), .OW(OW)) u_picker (
        .req    (bus.req),
        .rr_ptr (rr_ptr_q),
        .found  (found),
        .winner (winner)
    );

    // A beat happens in every BUSY cycle where the owner keeps req high.
    assign beat          = (state_q == BUSY) && bus.req[owner_q];
    assign release_burst = !bus.req[owner_q] || (beat && bus.last[owner_q]) || force_rel;
    assign rr_next       = (owner_q == OW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

    assign bus.mem_en    = beat;
    assign bus.mem_we    = beat && bus.we[owner_q];
    assign bus.mem_addr  = bus.addr[owner_q*ADDR_W +: ADDR_W];
    assign bus.mem_wdata = bus.wdata[owner_q*DATA_W +: DATA_W];
    assign bus.rdata     = bus.mem_rdata;
    assign bus.gnt       = gnt_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.busy      = (state_q == BUSY);

    // State, owner, pointer, grant and read-valid registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= OW'(RR_PTR_RST);
            gnt_q    <= '0;
            rvalid_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Grant in IDLE, sequence beats in BUSY, release back through IDLE.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        gnt_d    = gnt_q;
        rvalid_d = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d        = BUSY;
                    owner_d        = winner;
                    gnt_d          = '0;
                    gnt_d[winner]  = 1'b1;
                end
            end
            BUSY: begin
                if (beat && !bus.we[owner_q]) rvalid_d[owner_q] = 1'b1;
                if (release_burst) begin
                    state_d  = IDLE;
                    gnt_d    = '0;
                    rr_ptr_d = rr_next;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef PLESS_ARB_TIMEOUT_EN
    localparam int BW = $clog2(MAX_BEATS + 1);

    logic [BW-1:0] beat_cnt_q;
    logic          err_q;

    // MAX_BEATS-th beat without last ends the burst as if it carried last.
    assign force_rel       = beat && !bus.last[owner_q] && (beat_cnt_q == BW'(MAX_BEATS - 1));
    assign bus.err_timeout = err_q;

    // Beat counter cleared on grant; sticky overrun flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (state_q == IDLE && found) beat_cnt_q <= '0;
            else if (beat)                beat_cnt_q <= beat_cnt_q + 1'b1;
            if (force_rel) err_q <= 1'b1;
        end
    end
`else
    logic unused_max_beats;
    assign unused_max_beats = (MAX_BEATS > 0);
    assign force_rel        = 1'b0;
    assign bus.err_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_pless_mem_arbiter.sv
// Self-checking bench for pless_mem_arbiter: table-driven fairness vectors,
// hand sequences for bursts/drop/reset/watchdog, scoreboard for grants and reads.
module tb_pless_mem_arbiter;

    localparam int N  = 3;
    localparam int AW = 6;
    localparam int DW = 8;
    localparam int MB = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pless_mem_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus();

    pless_mem_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BEATS(MB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [N-1:0] who;
        logic [DW-1:0] data;
    } rd_t;

    typedef struct {
        logic [N-1:0]  req;
        logic [N-1:0]  we;
        logic [N-1:0]  last;
        logic [N-1:0]  gnt;
        logic          busy;
        logic          mem_en;
        logic [AW-1:0] mem_addr;
        logic [DW-1:0] mem_wdata;
    } vec_t;

    rd_t  rdq[$];
    int   gq[$];
    vec_t vt[8];
    logic [DW-1:0] mem [64];
    logic [N-1:0]  prev_gnt;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, got, exp);
        end
    endtask

    // Memory model: one-cycle read latency.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[5]        <= 8'hA5;
            mem[6]        <= 8'h66;
            bus.mem_rdata <= '0;
        end else if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= mem[bus.mem_addr];
        end
    end

    // Scoreboard monitor: grant order and read returns.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.gnt != '0 && prev_gnt == '0) begin
                if (gq.size() == 0) chk("gnt_unexpected", 32'(bus.gnt), 32'd0);
                else begin
                    int e;
                    e = gq.pop_front();
                    chk("gnt_order", 32'(bus.gnt), 32'(1 << e));
                end
            end
            if (bus.rvalid != '0) begin
                if (rdq.size() == 0) chk("rvalid_unexpected", 32'(bus.rvalid), 32'd0);
                else begin
                    rd_t r;
                    r = rdq.pop_front();
                    chk("rd_data", 32'({bus.rvalid, bus.rdata}), 32'({r.who, r.data}));
                end
            end
        end
        prev_gnt <= bus.gnt;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        #1;
    endtask

    task automatic drv(input int i, input logic r, input logic w, input logic l,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req[i]            = r;
        bus.we[i]             = w;
        bus.last[i]           = l;
        bus.addr[i*AW +: AW]  = a;
        bus.wdata[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        bus.req    = '0;
        bus.we     = '0;
        bus.last   = '0;
        bus.addr   = '0;
        bus.wdata  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt",    32'(bus.gnt), 32'd0);
        chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
        chk("rst_ctl",    32'({bus.busy, bus.mem_en, bus.mem_we}), 32'd0);
        chk("rst_err",    32'(bus.err_timeout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(input logic [N-1:0] g, input logic b, input logic en,
                                input logic [AW-1:0] a, input logic [DW-1:0] d);
        vec_t v;
        v.req = '1; v.we = '1; v.last = '1;
        v.gnt = g; v.busy = b; v.mem_en = en; v.mem_addr = a; v.mem_wdata = d;
        return v;
    endfunction

    initial begin
        vt[0] = mk(3'b000, 1'b0, 1'b0, 6'd0,  8'h00);
        vt[1] = mk(3'b001, 1'b1, 1'b1, 6'd20, 8'h10);
        vt[2] = mk(3'b000, 1'b0, 1'b0, 6'd0,  8'h00);
        vt[3] = mk(3'b010, 1'b1, 1'b1, 6'd21, 8'h11);
        vt[4] = mk(3'b000, 1'b0, 1'b0, 6'd0,  8'h00);
        vt[5] = mk(3'b100, 1'b1, 1'b1, 6'd22, 8'h12);
        vt[6] = mk(3'b000, 1'b0, 1'b0, 6'd0,  8'h00);
        vt[7] = mk(3'b001, 1'b1, 1'b1, 6'd20, 8'h10);

        // Single read, one-cycle grant and read latency.
        do_reset();
        gq.push_back(0);
        tick(); drv(0, 1, 0, 1, 6'd5, 8'h00); look();
        chk("t1_idle_gnt", 32'(bus.gnt), 32'd0);
        tick(); look();
        chk("t1_gnt", 32'(bus.gnt), 32'b001);
        chk("t1_mem", 32'({bus.mem_en, bus.mem_we, bus.mem_addr}), 32'({1'b1, 1'b0, 6'd5}));
        rdq.push_back('{who: 3'b001, data: 8'hA5});
        tick(); drv(0, 0, 0, 0, 6'd0, 8'h00); look();
        chk("t1_release", 32'({bus.busy, bus.gnt}), 32'd0);
        tick();

        // Fairness: all requesters issuing single writes.
        do_reset();
        gq.push_back(0); gq.push_back(1); gq.push_back(2); gq.push_back(0);
        for (int i = 0; i < N; i++) drv(i, 0, 1, 1, 6'(20 + i), 8'(8'h10 + i));
        for (int i = 0; i < 8; i++) begin
            tick();
            bus.req = vt[i].req; bus.we = vt[i].we; bus.last = vt[i].last;
            look();
            chk($sformatf("vec%0d_ctl", i), 32'({bus.gnt, bus.busy, bus.mem_en, bus.mem_we}),
                32'({vt[i].gnt, vt[i].busy, vt[i].mem_en, vt[i].mem_en}));
            if (vt[i].mem_en)
                chk($sformatf("vec%0d_bus", i), 32'({bus.mem_addr, bus.mem_wdata}),
                    32'({vt[i].mem_addr, vt[i].mem_wdata}));
        end
        tick(); bus.req = '0;
        tick();

        // Locked 4-beat burst by requester 1 under contention, then read-back.
        do_reset();
        gq.push_back(0); gq.push_back(1); gq.push_back(2); gq.push_back(1);
        tick(); drv(0, 1, 1, 1, 6'd30, 8'h55); look();
        tick(); look();
        chk("t3_pre_gnt", 32'(bus.gnt), 32'b001);
        tick();
        drv(0, 1, 1, 1, 6'd31, 8'h56); drv(2, 1, 1, 1, 6'd32, 8'h57); drv(1, 1, 1, 0, 6'd10, 8'hA0);
        look();
        chk("t3_gap", 32'(bus.gnt), 32'd0);
        for (int b = 0; b < 4; b++) begin
            if (b > 0) tick();
            else tick();
            drv(1, 1, 1, (b == 3), 6'(10 + b), 8'(8'hA0 + b)); look();
            chk($sformatf("t3_b%0d_gnt", b), 32'(bus.gnt), 32'b010);
            chk($sformatf("t3_b%0d_bus", b), 32'({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}),
                32'({1'b1, 1'b1, 6'(10 + b), 8'(8'hA0 + b)}));
        end
        tick(); drv(1, 0, 0, 0, 6'd0, 8'h00); look();
        chk("t3_gap2", 32'({bus.busy, bus.gnt}), 32'd0);
        tick(); look();
        chk("t3_next_gnt", 32'(bus.gnt), 32'b100);
        chk("t3_next_bus", 32'({bus.mem_addr, bus.mem_wdata}), 32'({6'd32, 8'h57}));
        bus.req = '0;
        tick();
        tick(); drv(1, 1, 0, 0, 6'd10, 8'h00); look();
        for (int b = 0; b < 4; b++) begin
            tick(); drv(1, 1, 0, (b == 3), 6'(10 + b), 8'h00); look();
            chk($sformatf("t3_rd%0d_gnt", b), 32'({bus.gnt, bus.mem_en}), 32'({3'b010, 1'b1}));
            rdq.push_back('{who: 3'b010, data: 8'(8'hA0 + b)});
        end
        tick(); drv(1, 0, 0, 0, 6'd0, 8'h00); look();
        chk("t3_rd_done", 32'(bus.busy), 32'd0);
        tick();

        // Owner drops req mid-burst.
        do_reset();
        gq.push_back(0); gq.push_back(1);
        tick(); drv(0, 1, 1, 0, 6'd40, 8'h70); look();
        tick(); look();
        chk("t4_b0", 32'({bus.gnt, bus.mem_en, bus.mem_addr}), 32'({3'b001, 1'b1, 6'd40}));
        tick(); drv(0, 1, 1, 0, 6'd41, 8'h71); look();
        chk("t4_b1", 32'({bus.mem_en, bus.mem_addr}), 32'({1'b1, 6'd41}));
        tick(); drv(0, 0, 0, 0, 6'd0, 8'h00); drv(1, 1, 1, 1, 6'd45, 8'h75); look();
        chk("t4_drop", 32'({bus.busy, bus.mem_en}), 32'({1'b1, 1'b0}));
        tick(); drv(0, 1, 1, 1, 6'd44, 8'h74); look();
        chk("t4_idle", 32'({bus.busy, bus.gnt, bus.mem_en}), 32'd0);
        tick(); look();
        chk("t4_rr_adv", 32'(bus.gnt), 32'b010);
        bus.req = '0;
        tick(); tick();

        // Reset asserted in the middle of a read burst.
        do_reset();
        gq.push_back(0); gq.push_back(0);
        tick(); drv(0, 1, 0, 0, 6'd5, 8'h00); look();
        tick(); look();
        chk("t5_b0", 32'({bus.gnt, bus.mem_en, bus.mem_addr}), 32'({3'b001, 1'b1, 6'd5}));
        rdq.push_back('{who: 3'b001, data: 8'hA5});
        tick(); drv(0, 1, 0, 0, 6'd6, 8'h00); look();
        chk("t5_b1", 32'({bus.mem_en, bus.mem_addr}), 32'({1'b1, 6'd6}));
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_drop", 32'({bus.gnt, bus.rvalid, bus.mem_en, bus.busy}), 32'd0);
        drv(0, 1, 1, 1, 6'd7, 8'h01); drv(2, 1, 1, 1, 6'd8, 8'h02);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            chk("t5_rst_hold", 32'({bus.mem_en, bus.gnt}), 32'd0);
        end
        @(negedge clk); rst_n = 1'b1;
        tick(); look();
        chk("t5_post_rst_gnt", 32'(bus.gnt), 32'b001);
        bus.req = '0;
        tick(); tick();

        // Burst of 10 beats without last.
        do_reset();
        gq.push_back(2);
        tick(); drv(2, 1, 1, 0, 6'd50, 8'h90); look();
        chk("t6_idle", 32'(bus.busy), 32'd0);
`ifdef PLESS_ARB_TIMEOUT_EN
        for (int b = 0; b < MB; b++) begin
            tick(); drv(2, 1, 1, 0, 6'(50 + b), 8'(8'h90 + b)); look();
            chk($sformatf("t6_b%0d", b), 32'({bus.gnt, bus.mem_en, bus.mem_addr, bus.err_timeout}),
                32'({3'b100, 1'b1, 6'(50 + b), 1'b0}));
        end
        tick(); drv(2, 0, 0, 0, 6'd0, 8'h00); look();
        chk("t6_forced", 32'({bus.busy, bus.gnt, bus.mem_en, bus.err_timeout}), 32'({1'b0, 3'b000, 1'b0, 1'b1}));
        tick(); tick(); look();
        chk("t6_sticky", 32'(bus.err_timeout), 32'd1);
`else
        for (int b = 0; b < 10; b++) begin
            tick(); drv(2, 1, 1, 0, 6'(50 + b), 8'(8'h90 + b)); look();
            chk($sformatf("t6_b%0d", b), 32'({bus.gnt, bus.mem_en, bus.mem_addr, bus.err_timeout}),
                32'({3'b100, 1'b1, 6'(50 + b), 1'b0}));
        end
        tick(); drv(2, 0, 0, 0, 6'd0, 8'h00); look();
        chk("t6_drop", 32'({bus.busy, bus.mem_en}), 32'({1'b1, 1'b0}));
        tick(); look();
        chk("t6_end", 32'({bus.busy, bus.err_timeout}), 32'd0);
`endif
        tick(); tick();

        chk("gq_drained",  32'(gq.size()), 32'd0);
        chk("rdq_drained", 32'(rdq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pless_mem_arbiter.md
Name: pless_mem_arbiter

Overview:
- Round-robin arbiter and sequencer for the SoC's shared single-port scratch memory inside tt_um_eneadim_soc.
- Requesters are the pin-side host bridge, the DMA engine and the peripheral register block. Each issues single beats or locked bursts.
- The arbiter grants one owner at a time, muxes that owner's command onto the memory port and returns read data with a valid strobe.

Parameters:
N_REQ, 3, number of requesters (2..4)
ADDR_W, 6, memory word address width
DATA_W, 8, data width
MAX_BEATS, 8, burst beat limit (used only with the optional feature)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req  in  N_REQ  per-requester request; held high for the whole burst
we  in  N_REQ  per-requester write enable for the current beat
last  in  N_REQ  per-requester last-beat marker
addr  in  N_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
wdata  in  N_REQ*DATA_W  packed write data
gnt  out  N_REQ  one-hot grant, registered
rvalid  out  N_REQ  read data valid for requester i, registered
rdata  out  DATA_W  read data, broadcast (equals mem_rdata)
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid one cycle after a read strobe
busy  out  1  high while in BUSY
err_timeout  out  1  sticky burst-overrun flag

Behaviour:
- Reset (async assert, sync deassert by SoC reset logic): state=IDLE, gnt=0, rvalid=0, rr_ptr=0, beat count=0, err_timeout=0. mem_en/mem_we are 0 because they are derived from IDLE.
- Reset mid-burst: grant and any pending rvalid are dropped immediately. No memory strobe is issued after assertion.
- States: IDLE, BUSY.
- IDLE: if any req is high, pick the first requester at or after rr_ptr, cyclically. The next cycle is BUSY with owner registered and gnt[owner]=1. Grant latency is 1 cycle from req. IDLE with no req stays IDLE.
- BUSY, beat rule: a beat is accepted in every cycle with req[owner]=1.
  - mem_en=1; mem_we, mem_addr, mem_wdata come combinationally from the owner's slice.
  - Non-owner inputs are ignored.
- Read latency: a read beat (we=0) in cycle t gives rvalid[owner]=1 in cycle t+1, with rdata=mem_rdata. Back-to-back reads give back-to-back rvalid.
- Release conditions, each returning to IDLE next cycle with gnt=0 and rr_ptr=(owner+1) mod N_REQ:
  - an accepted beat with last[owner]=1;
  - req[owner] low while in BUSY (no beat that cycle).
- Re-arbitration gap: at least one IDLE cycle separates consecutive grants, including re-grant to the same requester.
- Trailing rvalid: an rvalid from a final read beat is still delivered in the IDLE cycle after release.
- Fairness: with all requesters continuously requesting single beats, grants rotate 0,1,2,0,... Worst-case wait is (N_REQ-1) bursts.
- Simultaneous requests in IDLE: resolved only by rr_ptr; there are no fixed priorities.
- busy = (state==BUSY).
- Width rules: owner index is clog2(N_REQ) bits. rr_ptr wraps from N_REQ-1 to 0.

Optional Feature:
- Macro PLESS_ARB_TIMEOUT_EN.
- Defined:
  - A beat counter clears on grant and increments per accepted beat.
  - When the MAX_BEATS-th beat is accepted without last, the arbiter force-releases exactly as for last, and err_timeout sets. err_timeout is sticky until reset.
- Undefined: no counter; err_timeout is tied to 0; bursts are unbounded.

Decomposition:
- Package pless_arb_pkg:
  - state enum (IDLE, BUSY);
  - OWNER_W function/localparam;
  - a reset-value constant for rr_ptr.
- Sub-module pless_rr_picker: combinational rotating-priority encoder.
  - Inputs: req vector, rr_ptr.
  - Outputs: found flag, winner index.
  - Instantiated once.

Test Plan:
- Reset then req=3'b001, single read of addr 5 with last=1, mem returns 8'hA5. Required: gnt[0] 1 cycle after req; mem_en/addr=5 during the beat; rvalid[0]=1, rdata=A5 the next cycle; then IDLE.
- req=3'b111 held, all single-beat writes with last=1. Required: grant order 0,1,2,0 with one IDLE cycle between grants; each beat's mem_wdata matches its owner.
- Requester 1 does a 4-beat write burst (addresses 10..13, last on beat 4) while 0 and 2 also request. Required: gnt[1] stays high for all 4 beats with no interleaving; the next grant goes to 2.
- Owner drops req mid-burst after 2 beats. Required: release with no further mem_en; rr_ptr advances.
- Assert rst_n low during a read burst. Required: gnt, rvalid, mem_en go 0 immediately; after reset the first grant goes to requester 0.
- With PLESS_ARB_TIMEOUT_EN and MAX_BEATS=8, a 10-beat burst without last. Required: forced release after beat 8; err_timeout=1 and held. Without the macro, all 10 beats complete and err_timeout stays 0.
